// File: rtl/riscv_pd_ras_pkg.sv
// riscv_pd_ras_pkg: shared types and opcode constants for the pre-decode stage.
package riscv_pd_ras_pkg;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [6:2] OPC_JAL    = 5'b11011;
    localparam logic [6:2] OPC_JALR   = 5'b11001;
    localparam logic [6:2] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;
    typedef logic [4:0] rsd_t;
    typedef struct packed {
        logic            bubble;
        logic [ILEN-1:0] instr;
    } instruction_t;
    typedef struct packed {
        logic breakpoint;
        logic illegal_instruction;
        logic misaligned_instruction;
    } exceptions_t;
    function automatic logic is_link(input rsd_t r);
        return r == REG_RA || r == REG_T0;
    endfunction
endpackage

// File: rtl/riscv_pd_ras_ras.sv
// riscv_ras: circular return-address stack; overflow silently drops the oldest entry.
module riscv_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            pushpop_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] tos_o,
    output logic            empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] tos, tos_nxt;
    logic [AW:0]   cnt;
    logic [XLEN-1:0] stack [DEPTH];
    logic do_push, do_pop, do_over;
    // a pop-then-push on an empty stack degenerates into a plain push
    assign do_push = push_i | (pushpop_i & empty_o);
    assign do_pop  = pop_i & !empty_o;
    assign do_over = pushpop_i & !empty_o;
    assign tos_nxt = tos + 1'b1;
    assign tos_o   = stack[tos];
    assign empty_o = cnt == '0;
    always_ff @(posedge clk_i, negedge rst_ni)
        if (!rst_ni) begin
            tos <= '0;
            cnt <= '0;
        end else if (clear_i) begin
            tos <= '0;
            cnt <= '0;
        end else if (do_push) begin
            tos <= tos_nxt;
            cnt <= cnt == (AW+1)'(DEPTH) ? cnt : cnt + 1'b1;
        end else if (do_pop) begin
            tos <= tos - 1'b1;
            cnt <= cnt - 1'b1;
        end
    always_ff @(posedge clk_i)
        if (!clear_i) begin
            if (do_push) stack[tos_nxt] <= data_i;
            else if (do_over) stack[tos] <= data_i;
        end
endmodule

// File: rtl/riscv_pd_ras.sv
// riscv_pd_ras: pre-decode stage with static/BPU branch prediction and a return-address stack.
module riscv_pd_ras
    import riscv_pd_ras_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] PC_INIT   = 'h200,
    parameter bit              HAS_BPU   = 0,
    parameter bit              HAS_RAS   = 1,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            id_stall_i,
    input  logic            du_stall_i,
    input  logic            bu_flush_i,
    input  logic            st_flush_i,
    input  logic [XLEN-1:0] bu_nxt_pc_i,
    input  logic [XLEN-1:0] st_nxt_pc_i,
    input  logic [1:0]      bp_bp_predict_i,
    input  logic [XLEN-1:0] if_pc_i,
    input  instruction_t    if_insn_i,
    input  exceptions_t     if_exceptions_i,
    input  logic            dbg_if_i,
    output logic            pd_stall_o,
    output logic            pd_flush_o,
    output rsd_t            pd_rs1_o,
    output rsd_t            pd_rs2_o,
    output logic [XLEN-1:0] pd_nxt_pc_o,
    output logic            pd_latch_nxt_pc_o,
    output logic [1:0]      pd_bp_predict_o,
    output logic [XLEN-1:0] pd_pc_o,
    output instruction_t    pd_insn_o,
    output exceptions_t     pd_exceptions_o,
    output logic            dbg_pd_o
);
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] imm_uj, imm_sb, ras_tos;
    logic valid, accept, is_jal, is_jalr, is_branch, rd_link, rs1_link, is_ret;
    logic taken, dtaken, ras_empty, ras_push, ras_pop, ras_pushpop;
    logic [1:0] bits;
    rsd_t rd, rs1;
    assign insn       = if_insn_i.instr;
    assign rd         = insn[11:7];
    assign rs1        = insn[19:15];
    assign pd_rs1_o   = rs1;
    assign pd_rs2_o   = insn[24:20];
    assign pd_stall_o = id_stall_i;
    assign pd_flush_o = bu_flush_i | st_flush_i;
    assign valid      = !if_insn_i.bubble;
    assign accept     = valid & !id_stall_i & !du_stall_i & !pd_flush_o;
    assign is_jal     = insn[1:0] == 2'b11 && insn[6:2] == OPC_JAL;
    assign is_jalr    = insn[1:0] == 2'b11 && insn[6:2] == OPC_JALR && insn[14:12] == 3'b000;
    assign is_branch  = insn[1:0] == 2'b11 && insn[6:2] == OPC_BRANCH;
    assign rd_link    = is_link(rd);
    assign rs1_link   = is_link(rs1);
    assign is_ret     = !rd_link & rs1_link;
    assign imm_uj     = {{(XLEN-20){insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
    assign imm_sb     = {{(XLEN-12){insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
    always_comb begin
        taken       = 1'b0;
        bits        = 2'b00;
        pd_nxt_pc_o = 'x;
        if (valid && is_jal) begin
            taken       = 1'b1;
            bits        = 2'b10;
            pd_nxt_pc_o = if_pc_i + imm_uj;
        end else if (valid && is_branch) begin
            taken       = HAS_BPU ? bp_bp_predict_i[1] : imm_sb[XLEN-1];
            bits        = HAS_BPU ? bp_bp_predict_i : {imm_sb[XLEN-1], 1'b0};
            pd_nxt_pc_o = if_pc_i + imm_sb;
        end else if (valid && is_jalr && is_ret && !ras_empty) begin
            taken       = 1'b1;
            bits        = 2'b10;
            pd_nxt_pc_o = ras_tos;
        end
    end
    assign pd_latch_nxt_pc_o = taken & !dtaken;
    assign ras_push    = accept & ((is_jal & rd_link) | (is_jalr & rd_link & (!rs1_link | rs1 == rd)));
    assign ras_pop     = accept & is_jalr & is_ret;
    assign ras_pushpop = accept & is_jalr & rd_link & rs1_link & rs1 != rd;
    generate
        if (HAS_RAS) begin : g_ras
            riscv_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .clear_i   (st_flush_i),
                .push_i    (ras_push),
                .pop_i     (ras_pop),
                .pushpop_i (ras_pushpop),
                .data_i    (if_pc_i + XLEN'(4)),
                .tos_o     (ras_tos),
                .empty_o   (ras_empty)
            );
        end else begin : g_no_ras
            assign ras_tos   = '0;
            assign ras_empty = 1'b1;
        end
    endgenerate
    always_ff @(posedge clk_i, negedge rst_ni)
        if (!rst_ni) begin
            pd_pc_o          <= PC_INIT;
            pd_insn_o.bubble <= 1'b1;
            pd_insn_o.instr  <= INSTR_NOP;
            pd_exceptions_o  <= '0;
            pd_bp_predict_o  <= 2'b00;
            dbg_pd_o         <= 1'b0;
            dtaken           <= 1'b0;
        end else begin
            pd_pc_o          <= st_flush_i ? st_nxt_pc_i : bu_flush_i ? bu_nxt_pc_i : id_stall_i ? pd_pc_o : if_pc_i;
            pd_insn_o.bubble <= pd_flush_o | du_stall_i | (id_stall_i ? pd_insn_o.bubble : if_insn_i.bubble);
            pd_insn_o.instr  <= id_stall_i ? pd_insn_o.instr : if_insn_i.instr;
            pd_exceptions_o  <= pd_flush_o ? '0 : id_stall_i ? pd_exceptions_o : if_exceptions_i;
            pd_bp_predict_o  <= id_stall_i ? pd_bp_predict_o : bits;
            dbg_pd_o         <= dbg_if_i;
            dtaken           <= taken & !pd_flush_o;
        end
endmodule

// File: tb/tb_riscv_pd_ras.sv
// tb_riscv_pd_ras: directed checks of prediction, redirect strobe, RAS and payload registers.
module tb_riscv_pd_ras;
    import riscv_pd_ras_pkg::*;
    logic clk_i = 1'b0;
    logic rst_ni, id_stall_i, du_stall_i, bu_flush_i, st_flush_i, dbg_if_i;
    logic [31:0] bu_nxt_pc_i, st_nxt_pc_i, if_pc_i;
    logic [1:0] bp_bp_predict_i;
    instruction_t if_insn_i;
    exceptions_t if_exceptions_i;
    logic pd_stall_o, pd_flush_o, pd_latch_nxt_pc_o, dbg_pd_o;
    rsd_t pd_rs1_o, pd_rs2_o;
    logic [31:0] pd_nxt_pc_o, pd_pc_o;
    logic [1:0] pd_bp_predict_o;
    instruction_t pd_insn_o;
    exceptions_t pd_exceptions_o;
    int checks = 0;
    int errors = 0;
    int strobes;

    riscv_pd_ras dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .id_stall_i(id_stall_i), .du_stall_i(du_stall_i),
        .bu_flush_i(bu_flush_i), .st_flush_i(st_flush_i), .bu_nxt_pc_i(bu_nxt_pc_i),
        .st_nxt_pc_i(st_nxt_pc_i), .bp_bp_predict_i(bp_bp_predict_i), .if_pc_i(if_pc_i),
        .if_insn_i(if_insn_i), .if_exceptions_i(if_exceptions_i), .dbg_if_i(dbg_if_i),
        .pd_stall_o(pd_stall_o), .pd_flush_o(pd_flush_o), .pd_rs1_o(pd_rs1_o), .pd_rs2_o(pd_rs2_o),
        .pd_nxt_pc_o(pd_nxt_pc_o), .pd_latch_nxt_pc_o(pd_latch_nxt_pc_o),
        .pd_bp_predict_o(pd_bp_predict_o), .pd_pc_o(pd_pc_o), .pd_insn_o(pd_insn_o),
        .pd_exceptions_o(pd_exceptions_o), .dbg_pd_o(dbg_pd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h000, rs1, 3'b000, rd, 7'b1100111};
    endfunction
    function automatic logic [31:0] enc_beq(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask
    task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
        if_pc_i = pc;
        if_insn_i.instr = ins;
        if_insn_i.bubble = 1'b0;
        #1;
    endtask
    task automatic idle;
        if_insn_i.bubble = 1'b1;
        if_insn_i.instr = INSTR_NOP;
        tick;
    endtask

    initial begin
        rst_ni = 1'b0; id_stall_i = 1'b0; du_stall_i = 1'b0; bu_flush_i = 1'b0; st_flush_i = 1'b0;
        dbg_if_i = 1'b0; bu_nxt_pc_i = '0; st_nxt_pc_i = '0; if_pc_i = '0; bp_bp_predict_i = 2'b00;
        if_insn_i.bubble = 1'b1; if_insn_i.instr = INSTR_NOP; if_exceptions_i = '0;
        repeat (2) tick;
        check("rst_pc", pd_pc_o, 32'h200);
        check("rst_bubble", pd_insn_o.bubble, 1'b1);
        check("rst_insn", pd_insn_o.instr, INSTR_NOP);
        check("rst_exc", pd_exceptions_o, 3'b000);
        check("rst_bp", pd_bp_predict_o, 2'b00);
        check("rst_dbg", dbg_pd_o, 1'b0);
        check("rst_latch", pd_latch_nxt_pc_o, 1'b0);
        rst_ni = 1'b1;
        id_stall_i = 1'b1; bu_flush_i = 1'b1; #1;
        check("stall_pass", pd_stall_o, 1'b1);
        check("flush_or", pd_flush_o, 1'b1);
        id_stall_i = 1'b0; bu_flush_i = 1'b0; bu_nxt_pc_i = 32'h200;
        tick;
        // call then return through x1
        drive(32'h100, enc_jal(5'd1, 21'h40));
        check("jal_tgt", pd_nxt_pc_o, 32'h140);
        check("jal_strobe", pd_latch_nxt_pc_o, 1'b1);
        tick;
        check("jal_pdpc", pd_pc_o, 32'h100);
        check("jal_bits", pd_bp_predict_o, 2'b10);
        check("jal_insn", pd_insn_o.instr, enc_jal(5'd1, 21'h40));
        idle;
        check("jal_strobe_off", pd_latch_nxt_pc_o, 1'b0);
        drive(32'h200, enc_jalr(5'd0, 5'd1));
        check("ret_tgt", pd_nxt_pc_o, 32'h104);
        check("ret_strobe", pd_latch_nxt_pc_o, 1'b1);
        check("ret_rs1", pd_rs1_o, 5'd1);
        tick;
        check("ret_bits", pd_bp_predict_o, 2'b10);
        idle;
        drive(32'h210, enc_jalr(5'd0, 5'd1));
        check("ret_empty_strobe", pd_latch_nxt_pc_o, 1'b0);
        tick;
        check("ret_empty_bits", pd_bp_predict_o, 2'b00);
        idle;
        // five calls overflow a four-entry stack
        for (int k = 0; k < 5; k++) begin
            drive(32'h1000 + 32'(k) * 32'h100, enc_jal(5'd1, 21'h10));
            tick;
            idle;
        end
        for (int k = 0; k < 5; k++) begin
            drive(32'h2000 + 32'(k) * 32'h10, enc_jalr(5'd0, 5'd1));
            if (k < 4) begin
                check($sformatf("ovf_tgt%0d", k), pd_nxt_pc_o, 32'h1404 - 32'(k) * 32'h100);
                check($sformatf("ovf_strobe%0d", k), pd_latch_nxt_pc_o, 1'b1);
            end else begin
                check("ovf_5th_strobe", pd_latch_nxt_pc_o, 1'b0);
            end
            tick;
            idle;
        end
        // static branch prediction
        drive(32'h300, enc_beq(13'h1ff8));
        check("bwd_tgt", pd_nxt_pc_o, 32'h2f8);
        check("bwd_strobe", pd_latch_nxt_pc_o, 1'b1);
        tick;
        check("bwd_bits", pd_bp_predict_o, 2'b10);
        idle;
        drive(32'h310, enc_beq(13'h0008));
        check("fwd_strobe", pd_latch_nxt_pc_o, 1'b0);
        tick;
        check("fwd_bits", pd_bp_predict_o, 2'b00);
        idle;
        // call held by ID stall: one strobe, one push
        id_stall_i = 1'b1;
        drive(32'h400, enc_jal(5'd1, 21'h20));
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            strobes += int'(pd_latch_nxt_pc_o);
            tick;
        end
        check("stall_hold_pc", pd_pc_o, 32'h310);
        id_stall_i = 1'b0; #1;
        strobes += int'(pd_latch_nxt_pc_o);
        check("stall_strobes", strobes, 1);
        tick;
        check("stall_release_pc", pd_pc_o, 32'h400);
        idle;
        drive(32'h500, enc_jalr(5'd0, 5'd1));
        check("stall_ret_tgt", pd_nxt_pc_o, 32'h404);
        tick;
        idle;
        drive(32'h510, enc_jalr(5'd0, 5'd5));
        check("stall_single_push", pd_latch_nxt_pc_o, 1'b0);
        tick;
        idle;
        // state flush empties the stack
        drive(32'h600, enc_jal(5'd5, 21'h8));
        tick;
        idle;
        st_flush_i = 1'b1; st_nxt_pc_i = 32'h700;
        tick;
        check("st_flush_pc", pd_pc_o, 32'h700);
        check("st_flush_bubble", pd_insn_o.bubble, 1'b1);
        st_flush_i = 1'b0;
        drive(32'h710, enc_jalr(5'd0, 5'd1));
        check("st_flush_ras", pd_latch_nxt_pc_o, 1'b0);
        tick;
        idle;
        // branch flush keeps the stack and blocks a same-cycle push
        drive(32'h800, enc_jal(5'd1, 21'h8));
        tick;
        idle;
        bu_flush_i = 1'b1; bu_nxt_pc_i = 32'h900;
        drive(32'h880, enc_jal(5'd1, 21'h8));
        tick;
        check("bu_flush_pc", pd_pc_o, 32'h900);
        check("bu_flush_bubble", pd_insn_o.bubble, 1'b1);
        bu_flush_i = 1'b0;
        idle;
        drive(32'h910, enc_jalr(5'd0, 5'd1));
        check("bu_flush_ras_tgt", pd_nxt_pc_o, 32'h804);
        check("bu_flush_ras_strobe", pd_latch_nxt_pc_o, 1'b1);
        tick;
        idle;
        // exceptions and debug bubble
        if_exceptions_i = 3'b101;
        drive(32'ha00, INSTR_NOP);
        tick;
        check("exc_pass", pd_exceptions_o, 3'b101);
        st_flush_i = 1'b1;
        tick;
        check("exc_flush", pd_exceptions_o, 3'b000);
        st_flush_i = 1'b0; if_exceptions_i = '0;
        du_stall_i = 1'b1;
        drive(32'ha10, INSTR_NOP);
        tick;
        check("du_bubble", pd_insn_o.bubble, 1'b1);
        du_stall_i = 1'b0;
        tick;
        check("du_release", pd_insn_o.bubble, 1'b0);
        idle;
        // asynchronous reset in the middle of a stall
        drive(32'hb00, enc_jal(5'd1, 21'h8));
        tick;
        idle;
        dbg_if_i = 1'b1; id_stall_i = 1'b1;
        drive(32'hb10, INSTR_NOP);
        tick;
        check("dbg_delay", dbg_pd_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        check("mrst_pc", pd_pc_o, 32'h200);
        check("mrst_bubble", pd_insn_o.bubble, 1'b1);
        check("mrst_insn", pd_insn_o.instr, INSTR_NOP);
        check("mrst_bp", pd_bp_predict_o, 2'b00);
        check("mrst_dbg", dbg_pd_o, 1'b0);
        check("mrst_latch", pd_latch_nxt_pc_o, 1'b0);
        id_stall_i = 1'b0; dbg_if_i = 1'b0;
        tick;
        rst_ni = 1'b1;
        drive(32'hc00, enc_jalr(5'd0, 5'd1));
        check("mrst_ras_empty", pd_latch_nxt_pc_o, 1'b0);
        tick;
        idle;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
